// File: rtl/gray_img_server.sv
// Gray-image responder: loads a 128x128 8-bit image from the host, then serves
// 1-cycle-latency reads to the LBP core. Optional macro GRAY_REQ_CNT_EN adds req_cnt.
module gray_img_server #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [7:0]        gray_data,
  input  logic              finish,
  input  logic              restart,
  output logic              busy
`ifdef GRAY_REQ_CNT_EN
  ,
  output logic [ADDR_W+2:0] req_cnt
`endif
);

  localparam int IMG_SZ = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_SZ - 1);
  localparam logic [ADDR_W:0]   IMG_SZ_L  = (ADDR_W + 1)'(IMG_SZ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [7:0]        mem_r [0:IMG_SZ-1];
  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [ADDR_W-1:0] wr_cnt_r;
  logic              load_ready_r;
  logic              gray_ready_r;
  logic              busy_r;
  logic [7:0]        gray_data_r;
  logic              xfer_s;
  logic              last_s;
  logic              rd_en_s;
  logic              rd_hit_s;

  assign load_ready = load_ready_r;
  assign gray_ready = gray_ready_r;
  assign busy       = busy_r;
  assign gray_data  = gray_data_r;

  // Transfer qualification; restart discards a same-cycle pixel.
  always_comb begin
    xfer_s   = (state_r == ST_LOAD) && load_valid && load_ready_r && !restart;
    last_s   = (wr_cnt_r == LAST_ADDR);
    rd_en_s  = (state_r == ST_SERVE) && gray_req;
    rd_hit_s = ({1'b0, gray_addr} < IMG_SZ_L);
  end

  // Next-state decode; the reserved IDLE code falls into LOAD.
  always_comb begin
    state_nxt_s = state_r;
    if (restart) begin
      state_nxt_s = ST_LOAD;
    end else begin
      case (state_r)
        ST_LOAD:  state_nxt_s = (xfer_s && last_s) ? ST_SERVE : ST_LOAD;
        ST_SERVE: state_nxt_s = finish ? ST_DONE : ST_SERVE;
        ST_DONE:  state_nxt_s = ST_DONE;
        ST_IDLE:  state_nxt_s = ST_LOAD;
        default:  state_nxt_s = ST_LOAD;
      endcase
    end
  end

  // Control state, write counter and status flags derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_LOAD;
      wr_cnt_r     <= {ADDR_W{1'b0}};
      load_ready_r <= 1'b0;
      gray_ready_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      load_ready_r <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_IDLE);
      gray_ready_r <= (state_nxt_s == ST_SERVE);
      busy_r       <= (state_nxt_s != ST_DONE);
      if (restart) begin
        wr_cnt_r <= {ADDR_W{1'b0}};
      end else if (xfer_s) begin
        wr_cnt_r <= last_s ? {ADDR_W{1'b0}} : wr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        wr_cnt_r <= wr_cnt_r;
      end
    end
  end

  // Image storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      mem_r[wr_cnt_r] <= load_data;
    end
  end

  // Registered read port; holds when no request is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gray_data_r <= 8'h00;
    end else if (rd_en_s) begin
      gray_data_r <= rd_hit_s ? mem_r[gray_addr] : 8'h00;
    end else begin
      gray_data_r <= gray_data_r;
    end
  end

`ifdef GRAY_REQ_CNT_EN
  logic [ADDR_W+2:0] req_cnt_r;
  assign req_cnt = req_cnt_r;

  // Saturating count of reads accepted in SERVE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_cnt_r <= {(ADDR_W+3){1'b0}};
    end else if (restart) begin
      req_cnt_r <= {(ADDR_W+3){1'b0}};
    end else if (rd_en_s && !(&req_cnt_r)) begin
      req_cnt_r <= req_cnt_r + {{(ADDR_W+2){1'b0}}, 1'b1};
    end else begin
      req_cnt_r <= req_cnt_r;
    end
  end
`endif

endmodule
